afu_rd_arbiter: RTL and testbench

- Parametrised read-request arbiter and response router for NUM_CH accelerator channels sharing one host read port (CCI c0).
- Sits between the per-AFU read engines inside afu_manager and the host read request/response interface.
- Generalises single-requester read issue with:
  - round-robin arbitration,
  - per-channel enable,
  - per-channel outstanding-request credit limits,
  - channel-ID tagging in mdata,
  - registered response demultiplexing,
  - per-channel issued-read counters for the info CSRs.

---
 rtl/afu_rd_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/afu_rd_arbiter.sv | 135 +++++++++++++
 tb/tb_afu_rd_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/afu_rd_arb_pkg.sv
// Shared types and mdata packing helpers for the AFU read arbiter.
// Default widths here also seed the top-level parameter defaults.
package afu_rd_arb_pkg;

  localparam int unsigned PKG_CH_ID_W  = 4;
  localparam int unsigned PKG_MDATA_W  = 16;
  localparam int unsigned PKG_TAG_W    = PKG_MDATA_W - PKG_CH_ID_W;
  localparam int unsigned PKG_MAX_OUTST = 32;
  localparam int unsigned OUTST_W      = $clog2(PKG_MAX_OUTST) + 1;

  typedef logic [PKG_CH_ID_W-1:0] ch_id_t;

  function automatic logic [PKG_MDATA_W-1:0] pack_mdata(ch_id_t id, logic [PKG_TAG_W-1:0] tag);
    return {id, tag};
  endfunction

  function automatic ch_id_t unpack_id(logic [PKG_MDATA_W-1:0] mdata);
    return mdata[PKG_MDATA_W-1 -: PKG_CH_ID_W];
  endfunction

  function automatic logic [PKG_TAG_W-1:0] unpack_tag(logic [PKG_MDATA_W-1:0] mdata);
    return mdata[PKG_TAG_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
// The last-grant pointer moves only when a grant is taken with advance high.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] cand;
  logic [IW-1:0] win;
  logic          found;

  always_comb begin
    gnt   = '0;
    cand  = '0;
    win   = last_q;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(last_q) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        win       = cand;
      end
    end
    last_d = (advance && found) ? win : last_q;
  end

  // Reset to N-1 so channel 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/afu_rd_arbiter.sv
// Shares one host read port among NUM_CH channels: credit-limited round-robin issue
// with channel-ID tagging, and registered response routing back by mdata ID.
module afu_rd_arbiter
  import afu_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ADDR_W    = 48,
  parameter int unsigned MDATA_W   = PKG_MDATA_W,
  parameter int unsigned CH_ID_W   = PKG_CH_ID_W,
  parameter int unsigned MAX_OUTST = PKG_MAX_OUTST,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_CH-1:0]                            ch_en,
  input  logic [NUM_CH-1:0]                            ch_req_valid,
  output logic [NUM_CH-1:0]                            ch_req_ready,
  input  logic [NUM_CH*ADDR_W-1:0]                     ch_req_addr,
  input  logic [NUM_CH*(MDATA_W-CH_ID_W)-1:0]          ch_req_tag,
  input  logic                                         req_rd_available,
  output logic                                         req_rd_en,
  output logic [ADDR_W-1:0]                            req_rd_addr,
  output logic [MDATA_W-1:0]                           req_rd_mdata,
  input  logic                                         resp_rd_valid,
  input  logic [DATA_W-1:0]                            resp_rd_data,
  input  logic [MDATA_W-1:0]                           resp_rd_mdata,
  output logic [NUM_CH-1:0]                            ch_resp_valid,
  output logic [DATA_W-1:0]                            ch_resp_data,
  output logic [MDATA_W-CH_ID_W-1:0]                   ch_resp_tag,
  output logic [NUM_CH*($clog2(MAX_OUTST)+1)-1:0]      ch_outst,
  output logic [NUM_CH*CNT_W-1:0]                      ch_rd_count
);

  localparam int unsigned TAG_W = MDATA_W - CH_ID_W;
  localparam int unsigned OW    = $clog2(MAX_OUTST) + 1;
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);

  logic [OW-1:0]      outst_q [NUM_CH];
  logic [CNT_W-1:0]   cnt_q   [NUM_CH];
  logic [NUM_CH-1:0]  elig, arb_req, gnt, dec;
  logic [ADDR_W-1:0]  sel_addr;
  logic [TAG_W-1:0]   sel_tag;
  logic [CH_ID_W-1:0] sel_id;
  logic [CH_ID_W-1:0] resp_id;

  logic               req_en_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [MDATA_W-1:0] mdata_q;
  logic [NUM_CH-1:0]  resp_valid_q;
  logic [DATA_W-1:0]  resp_data_q;
  logic [TAG_W-1:0]   resp_tag_q;
  logic               err_q;

  always_comb begin
    resp_id = resp_rd_mdata[MDATA_W-1 -: CH_ID_W];
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      elig[i] = ch_en[i] & ch_req_valid[i] & (outst_q[i] < OUTST_MAX);
      // Responses for unknown channels or with no credit outstanding are dropped.
      dec[i]  = resp_rd_valid & (resp_id == CH_ID_W'(i)) & (outst_q[i] != '0);
    end
    arb_req = elig & {NUM_CH{req_rd_available & ~rst}};
  end

  rr_arbiter #(
    .N (NUM_CH)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (req_rd_available),
    .gnt     (gnt)
  );

  always_comb begin
    sel_addr = '0;
    sel_tag  = '0;
    sel_id   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_addr = ch_req_addr[i*ADDR_W +: ADDR_W];
        sel_tag  = ch_req_tag[i*TAG_W +: TAG_W];
        sel_id   = CH_ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_en_q     <= 1'b0;
      addr_q       <= '0;
      mdata_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      err_q        <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        outst_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      req_en_q     <= |gnt;
      resp_valid_q <= dec;
      if (|gnt) begin
        addr_q  <= sel_addr;
        mdata_q <= {sel_id, sel_tag};
      end
      if (resp_rd_valid) begin
        resp_data_q <= resp_rd_data;
        resp_tag_q  <= resp_rd_mdata[TAG_W-1:0];
      end
      if (resp_rd_valid && !(|dec)) begin
        err_q <= 1'b1;
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        outst_q[i] <= outst_q[i] + OW'(gnt[i]) - OW'(dec[i]);
        cnt_q[i]   <= cnt_q[i] + CNT_W'(gnt[i]);
      end
    end
  end

  assign ch_req_ready  = gnt;
  assign req_rd_en     = req_en_q;
  assign req_rd_addr   = addr_q;
  assign req_rd_mdata  = mdata_q;
  assign ch_resp_valid = resp_valid_q;
  assign ch_resp_data  = resp_data_q;
  assign ch_resp_tag   = resp_tag_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign ch_outst[g*OW +: OW]         = outst_q[g];
    assign ch_rd_count[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_afu_rd_arbiter.sv
// Bench for afu_rd_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_afu_rd_arbiter;
  import afu_rd_arb_pkg::*;

  localparam int NCH = 4;
  localparam int AW  = 48;
  localparam int MW  = 16;
  localparam int IDW = 4;
  localparam int MO  = 32;
  localparam int DW  = 512;
  localparam int CW  = 32;
  localparam int TW  = MW - IDW;
  localparam int OW  = $clog2(MO) + 1;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    ch_en, ch_req_valid, ch_req_ready;
  logic [NCH*AW-1:0] ch_req_addr;
  logic [NCH*TW-1:0] ch_req_tag;
  logic              req_rd_available, req_rd_en;
  logic [AW-1:0]     req_rd_addr;
  logic [MW-1:0]     req_rd_mdata;
  logic              resp_rd_valid;
  logic [DW-1:0]     resp_rd_data;
  logic [MW-1:0]     resp_rd_mdata;
  logic [NCH-1:0]    ch_resp_valid;
  logic [DW-1:0]     ch_resp_data;
  logic [TW-1:0]     ch_resp_tag;
  logic [NCH*OW-1:0] ch_outst;
  logic [NCH*CW-1:0] ch_rd_count;

  afu_rd_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .MDATA_W(MW), .CH_ID_W(IDW),
    .MAX_OUTST(MO), .DATA_W(DW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .ch_req_valid(ch_req_valid),
    .ch_req_ready(ch_req_ready), .ch_req_addr(ch_req_addr), .ch_req_tag(ch_req_tag),
    .req_rd_available(req_rd_available), .req_rd_en(req_rd_en), .req_rd_addr(req_rd_addr),
    .req_rd_mdata(req_rd_mdata), .resp_rd_valid(resp_rd_valid), .resp_rd_data(resp_rd_data),
    .resp_rd_mdata(resp_rd_mdata), .ch_resp_valid(ch_resp_valid), .ch_resp_data(ch_resp_data),
    .ch_resp_tag(ch_resp_tag), .ch_outst(ch_outst), .ch_rd_count(ch_rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: state after the most recent clock edge.
  bit          mon = 1'b0;
  int          m_last;
  int          m_outst [NCH];
  logic [31:0] m_cnt   [NCH];
  logic        e_en;
  logic [AW-1:0] e_addr;
  logic [MW-1:0] e_mdata;
  logic [NCH-1:0] e_rv;
  logic [DW-1:0] e_rd;
  logic [TW-1:0] e_rt;
  bit          m_err;

  always @(negedge clk) begin : p_model
    int g, d, rid, c;
    logic [NCH-1:0] e_rdy;
    g = -1;
    if (!rst && req_rd_available) begin
      for (int k = 1; k <= NCH; k++) begin
        c = (m_last + k) % NCH;
        if (g < 0 && ch_en[c] && ch_req_valid[c] && m_outst[c] < MO) g = c;
      end
    end
    e_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
    if (mon) begin
      chk("ready", ch_req_ready, e_rdy);
      chk("rd_en", req_rd_en, e_en);
      chk("rd_addr", req_rd_addr, e_addr);
      chk("rd_mdata", req_rd_mdata, e_mdata);
      chk("resp_valid", ch_resp_valid, e_rv);
      chk("resp_data", ch_resp_data, e_rd);
      chk("resp_tag", ch_resp_tag, e_rt);
      chk("err", dut.err_q, m_err);
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("outst%0d", i), ch_outst[i*OW +: OW], m_outst[i]);
        chk($sformatf("rd_count%0d", i), ch_rd_count[i*CW +: CW], m_cnt[i]);
      end
    end
    if (rst) begin
      mon    = 1'b1;
      m_last = NCH - 1;
      for (int i = 0; i < NCH; i++) begin
        m_outst[i] = 0;
        m_cnt[i]   = '0;
      end
      e_en = 0; e_addr = '0; e_mdata = '0; e_rv = '0; e_rd = '0; e_rt = '0; m_err = 0;
    end else begin
      if (g >= 0) begin
        e_en    = 1'b1;
        e_addr  = ch_req_addr[g*AW +: AW];
        e_mdata = pack_mdata(ch_id_t'(g), ch_req_tag[g*TW +: TW]);
        m_last  = g;
        m_cnt[g] = m_cnt[g] + 1;
      end else begin
        e_en = 1'b0;
      end
      d = -1;
      if (resp_rd_valid) begin
        rid = int'(unpack_id(resp_rd_mdata));
        if (rid < NCH && m_outst[rid] > 0) d = rid;
        else m_err = 1'b1;
        e_rd = resp_rd_data;
        e_rt = resp_rd_mdata[TW-1:0];
      end
      e_rv = (d >= 0) ? 4'(1 << d) : 4'd0;
      if (g >= 0) m_outst[g]++;
      if (d >= 0) m_outst[d]--;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic rand_addr_tag();
    for (int i = 0; i < NCH; i++) begin
      ch_req_addr[i*AW +: AW] = AW'({$urandom(), $urandom()});
      ch_req_tag[i*TW +: TW]  = TW'($urandom());
    end
  endtask

  initial begin : p_stim
    logic [NCH-1:0] exp_rdy;
    logic [DW-1:0]  pat;
    int             seq [3];
    int             rid;
    seq = '{0, 1, 3};
    rst = 1'b1;
    ch_en = '0; ch_req_valid = '0; req_rd_available = 1'b0;
    resp_rd_valid = 1'b0; resp_rd_data = '0; resp_rd_mdata = '0;
    rand_addr_tag();
    step();
    do_reset();

    // Plain round robin across all four channels.
    ch_en = '1; ch_req_valid = '1; req_rd_available = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_rdy = 4'b0001 << (k % 4);
      chk("t1_ready", ch_req_ready, exp_rdy);
      if (k > 0) chk("t1_mdata_id", req_rd_mdata[MW-1 -: IDW], (k - 1) % 4);
      step();
    end

    // Credit limit on channel 2.
    do_reset();
    ch_req_valid = 4'b0100;
    repeat (32) step();
    @(negedge clk);
    chk("t2_ready_full", ch_req_ready, 4'b0000);
    chk("t2_outst_full", ch_outst[2*OW +: OW], 32);
    step();
    resp_rd_valid = 1'b1; resp_rd_mdata = pack_mdata(ch_id_t'(2), 12'h005);
    @(negedge clk);
    chk("t2_ready_still", ch_req_ready, 4'b0000);
    step();
    resp_rd_valid = 1'b0;
    @(negedge clk);
    chk("t2_ready_credit", ch_req_ready, 4'b0100);
    step();
    @(negedge clk);
    chk("t2_ready_refull", ch_req_ready, 4'b0000);

    // Same-cycle grant and response on channel 1.
    do_reset();
    ch_req_valid = 4'b0010;
    repeat (5) step();
    pat = {16{32'hdeadbeef}};
    resp_rd_valid = 1'b1; resp_rd_data = pat; resp_rd_mdata = pack_mdata(ch_id_t'(1), 12'habc);
    step();
    ch_req_valid = '0; resp_rd_valid = 1'b0;
    @(negedge clk);
    chk("t3_outst1", ch_outst[1*OW +: OW], 5);
    chk("t3_resp_valid", ch_resp_valid, 4'b0010);
    chk("t3_resp_data", ch_resp_data, pat);
    chk("t3_resp_tag", ch_resp_tag, 12'habc);

    // Host availability toggling.
    do_reset();
    ch_req_valid = 4'b1001;
    @(negedge clk);
    chk("t4_ready_a", ch_req_ready, 4'b0001);
    step();
    req_rd_available = 1'b0;
    @(negedge clk);
    chk("t4_ready_b", ch_req_ready, 4'b0000);
    chk("t4_rd_en_a", req_rd_en, 1'b1);
    step();
    req_rd_available = 1'b1;
    @(negedge clk);
    chk("t4_ready_c", ch_req_ready, 4'b1000);
    chk("t4_rd_en_b", req_rd_en, 1'b0);
    step();
    @(negedge clk);
    chk("t4_rd_en_c", req_rd_en, 1'b1);

    // Channel 2 disabled, then a response with an out-of-range ID.
    do_reset();
    ch_en = 4'b1011; ch_req_valid = '1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      exp_rdy = 4'b0001 << seq[k % 3];
      chk("t5_ready", ch_req_ready, exp_rdy);
      step();
    end
    ch_req_valid = '0;
    resp_rd_valid = 1'b1; resp_rd_mdata = pack_mdata(ch_id_t'(7), 12'h000);
    step();
    resp_rd_valid = 1'b0;
    @(negedge clk);
    chk("t5_resp_valid", ch_resp_valid, 4'b0000);
    chk("t5_err", dut.err_q, 1'b1);
    step();

    // Reset mid-traffic, then a late response.
    ch_en = '1; ch_req_valid = 4'b0001;
    do_reset();
    repeat (10) step();
    rst = 1'b1; ch_req_valid = '0;
    step();
    rst = 1'b0;
    resp_rd_valid = 1'b1; resp_rd_mdata = pack_mdata(ch_id_t'(0), 12'h123);
    @(negedge clk);
    chk("t6_count0", ch_rd_count[0 +: CW], 0);
    step();
    resp_rd_valid = 1'b0; ch_req_valid = '1;
    @(negedge clk);
    chk("t6_outst0", ch_outst[0 +: OW], 0);
    chk("t6_first_grant", ch_req_ready, 4'b0001);
    step();

    // Randomized traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rand_addr_tag();
      ch_en            = ($urandom_range(99) < 70) ? 4'hF : 4'($urandom());
      ch_req_valid     = 4'($urandom()) | (($urandom_range(99) < 50) ? 4'hF : 4'h0);
      req_rd_available = ($urandom_range(99) < 85);
      resp_rd_valid    = ($urandom_range(99) < (((cyc / 500) % 2) ? 60 : 10));
      rid = ($urandom_range(99) < 90) ? $urandom_range(NCH - 1) : $urandom_range(15, 4);
      resp_rd_mdata    = pack_mdata(ch_id_t'(rid), TW'($urandom()));
      for (int w = 0; w < DW / 32; w++) resp_rd_data[w*32 +: 32] = $urandom();
      rst              = ($urandom_range(399) == 0);
      step();
    end
    rst = 1'b0; resp_rd_valid = 1'b0; ch_req_valid = '0;
    repeat (3) step();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
